// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: data-bus req/ack handshake between the LSU (master) and memory (slave)
//   dbus_req   master->slave  request, held with all request fields until ack
//   dbus_we    master->slave  write strobe
//   dbus_addr  master->slave  word address, low 2 bits zero
//   dbus_be    master->slave  byte enables
//   dbus_wdata master->slave  lane-replicated store data
//   dbus_ack   slave->master  completion
//   dbus_rdata slave->master  read data, valid with ack
interface mem_stage_lsu_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    input  dbus_ack, dbus_rdata
  );
  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata,
    output dbus_ack, dbus_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit running a req/ack data-bus transaction
//   clk, reset_n (async active-low)
//   mem_valid_m/read_m/write_m/size_m/sext_m, addr_m, wdata_m : M-stage access
//   stall_m : holds F/D/E/M while an access is issued or outstanding
//   load_data_m : lane-extracted, extended load result
//   bus_err : one-cycle pulse when WAIT times out after TIMEOUT_CYCLES cycles
//   align_err : one-cycle pulse on a misaligned access, only with LSU_ALIGN_CHECK_EN
//   dbus : mem_stage_lsu_if master port
module mem_stage_lsu #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_valid_m,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  mem_size_m,
  input  logic        mem_sext_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  output logic        stall_m,
  output logic [31:0] load_data_m,
  output logic        bus_err,
  output logic        align_err,
  mem_stage_lsu_if.master dbus
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic access, is_byte, is_half, align_fault, issue, timeout;
  logic [3:0] be_c;
  logic [31:0] wdata_c, rdata_ext;
  logic ld_read, ld_sext;
  logic [1:0] ld_size, ld_k;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  assign access = mem_valid_m & (mem_read_m | mem_write_m);
  assign is_byte = mem_size_m == 2'b10;
  assign is_half = mem_size_m == 2'b01;
`ifdef LSU_ALIGN_CHECK_EN
  assign align_fault = access & (is_half ? addr_m[0] : !is_byte && addr_m[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif
  assign issue = state == S_IDLE && access && !align_fault;
  // the WAIT cycle that sees ack is never a timeout, so ack wins on the last cycle
  assign timeout = state == S_WAIT && !dbus.dbus_ack && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
  assign be_c = is_byte ? 4'b0001 << addr_m[1:0] : is_half ? (addr_m[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_c = is_byte ? {4{wdata_m[7:0]}} : is_half ? {2{wdata_m[15:0]}} : wdata_m;
  assign rbyte = dbus.dbus_rdata[{ld_k, 3'b000} +: 8];
  assign rhalf = ld_k[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
  assign rdata_ext = ld_size == 2'b10 ? {{24{ld_sext & rbyte[7]}}, rbyte} :
                     ld_size == 2'b01 ? {{16{ld_sext & rhalf[15]}}, rhalf} : dbus.dbus_rdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == S_IDLE ? (access ? (align_fault ? S_DONE : S_WAIT) : S_IDLE) :
               state == S_WAIT ? (dbus.dbus_ack || timeout ? S_DONE : S_WAIT) : S_IDLE;
  always_comb
    stall_m = (state == S_IDLE && access) || state == S_WAIT;
  // request fields and the load shape are latched at issue so the M-stage inputs need not be trusted later
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      dbus.dbus_req <= 1'b0;
      dbus.dbus_we <= 1'b0;
      dbus.dbus_addr <= '0;
      dbus.dbus_be <= '0;
      dbus.dbus_wdata <= '0;
      load_data_m <= '0;
      bus_err <= 1'b0;
      align_err <= 1'b0;
      cnt <= '0;
      ld_read <= 1'b0;
      ld_sext <= 1'b0;
      ld_size <= '0;
      ld_k <= '0;
    end else begin
      bus_err <= timeout;
      align_err <= state == S_IDLE && align_fault;
      if (issue) begin
        dbus.dbus_req <= 1'b1;
        dbus.dbus_we <= mem_write_m;
        dbus.dbus_addr <= {addr_m[31:2], 2'b00};
        dbus.dbus_be <= be_c;
        dbus.dbus_wdata <= wdata_c;
        cnt <= '0;
        ld_read <= !mem_write_m;
        ld_sext <= mem_sext_m;
        ld_size <= mem_size_m;
        ld_k <= addr_m[1:0];
      end else if (state == S_WAIT) begin
        if (dbus.dbus_ack || timeout) begin
          dbus.dbus_req <= 1'b0;
          dbus.dbus_we <= 1'b0;
          dbus.dbus_be <= '0;
        end else cnt <= cnt + CNT_W'(1);
        if (dbus.dbus_ack && ld_read) load_data_m <= rdata_ext;
        else if (timeout) load_data_m <= '0;
      end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: vector table, corner sequences and randomized accesses checked against a spec-level model
module tb_mem_stage_lsu;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_valid_m = 1'b0, mem_read_m = 1'b0, mem_write_m = 1'b0, mem_sext_m = 1'b0;
  logic [1:0] mem_size_m = 2'b00;
  logic [31:0] addr_m = '0, wdata_m = '0;
  logic stall_m, bus_err, align_err;
  logic [31:0] load_data_m;
  logic [31:0] last_ld = '0;
  int cmp = 0, nerr = 0;
  mem_stage_lsu_if bus();
  mem_stage_lsu #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_valid_m(mem_valid_m), .mem_read_m(mem_read_m), .mem_write_m(mem_write_m),
    .mem_size_m(mem_size_m), .mem_sext_m(mem_sext_m), .addr_m(addr_m), .wdata_m(wdata_m),
    .stall_m(stall_m), .load_data_m(load_data_m), .bus_err(bus_err), .align_err(align_err),
    .dbus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rd, wr;
    logic [1:0] sz;
    logic sx;
    logic [31:0] a, wd, rdat;
    int wc;
    logic [3:0] e_be;
    logic [31:0] e_wd, e_ld;
  } vec_t;
  vec_t tbl[11];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // expected lanes and load value derived arithmetically from the byte-lane rules
  task automatic model(input logic [1:0] sz, input logic sx, input logic [31:0] a, wd, rdat,
                       output logic [3:0] be, output logic [31:0] ewd, eld);
    int k;
    logic [31:0] v;
    k = int'(a[1:0]);
    if (sz == 2'b10) begin
      be = 4'(1 << k);
      ewd = {24'h0, wd[7:0]} * 32'h01010101;
      v = (rdat >> (8 * k)) & 32'hFF;
      eld = (sx && v >= 32'd128) ? v + 32'hFFFFFF00 : v;
    end else if (sz == 2'b01) begin
      k = int'(a[1]);
      be = k == 1 ? 4'b1100 : 4'b0011;
      ewd = {16'h0, wd[15:0]} * 32'h00010001;
      v = (rdat >> (16 * k)) & 32'hFFFF;
      eld = (sx && v >= 32'd32768) ? v + 32'hFFFF0000 : v;
    end else begin
      be = 4'hF;
      ewd = wd;
      eld = rdat;
    end
  endtask
  // one full access: issue in IDLE, ack in the wc-th WAIT cycle, DONE checked, back to IDLE
  task automatic access(input logic rd, wr, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, wd, rdat, input int wc,
                        input logic [3:0] e_be, input logic [31:0] e_wd, e_ld);
    int st;
    @(negedge clk);
    mem_valid_m = 1'b1; mem_read_m = rd; mem_write_m = wr; mem_size_m = sz; mem_sext_m = sx;
    addr_m = a; wdata_m = wd; bus.dbus_ack = 1'b0;
    #1 check("stall_idle", 32'(stall_m), 32'd1);
    st = 1;
    @(negedge clk);
    if (stall_m) st++;
    check("req", 32'(bus.dbus_req), 32'd1);
    check("we", 32'(bus.dbus_we), 32'(wr));
    check("addr", bus.dbus_addr, a & 32'hFFFFFFFC);
    check("be", 32'(bus.dbus_be), 32'(e_be));
    check("wdata", bus.dbus_wdata, e_wd);
    for (int w = 1; w < wc; w++) begin
      @(negedge clk);
      if (stall_m) st++;
    end
    check("req_hold", 32'(bus.dbus_req), 32'd1);
    check("be_hold", 32'(bus.dbus_be), 32'(e_be));
    bus.dbus_ack = 1'b1; bus.dbus_rdata = rdat;
    @(negedge clk);
    bus.dbus_ack = 1'b0; bus.dbus_rdata = $urandom();
    check("stall_cycles", 32'(st), 32'(wc + 1));
    check("stall_done", 32'(stall_m), 32'd0);
    check("req_drop", 32'(bus.dbus_req), 32'd0);
    check("be_drop", 32'(bus.dbus_be), 32'd0);
    check("load_data", load_data_m, e_ld);
    check("bus_err_quiet", 32'(bus_err), 32'd0);
    check("align_err_quiet", 32'(align_err), 32'd0);
    mem_valid_m = 1'b0;
    last_ld = e_ld;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] be;
    logic [31:0] ewd, eld, a, wd, rdat;
    logic [1:0] sz;
    int op, n;
    bus.dbus_ack = 1'b0; bus.dbus_rdata = '0;
    tbl[0]  = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h1004, 32'hDEADBEEF, 32'h0, 2, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h2003, 32'h0, 32'h80000000, 1, 4'h8, 32'h0, 32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h2003, 32'h0, 32'h80000000, 3, 4'h8, 32'h0, 32'h00000080};
    tbl[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h12345678, 1, 4'hC, 32'h0, 32'h00001234};
    tbl[4]  = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h2000, 32'hABCD, 32'h0, 2, 4'h3, 32'hABCDABCD, 32'h00001234};
    tbl[5]  = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h3001, 32'h1234565A, 32'h0, 1, 4'h2, 32'h5A5A5A5A, 32'h00001234};
    tbl[6]  = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h4000, 32'h0, 32'h77778001, 2, 4'h3, 32'h0, 32'hFFFF8001};
    tbl[7]  = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0010, 32'h0, 32'hCAFEF00D, 3, 4'hF, 32'h0, 32'hCAFEF00D};
    tbl[8]  = '{1'b1, 1'b1, 2'b00, 1'b0, 32'h0020, 32'h11223344, 32'h99999999, 1, 4'hF, 32'h11223344, 32'hCAFEF00D};
    tbl[9]  = '{1'b1, 1'b0, 2'b11, 1'b1, 32'h0024, 32'h0, 32'h55AA55AA, 2, 4'hF, 32'h0, 32'h55AA55AA};
    tbl[10] = '{1'b1, 1'b0, 2'b10, 1'b1, 32'h5001, 32'h0, 32'h00007F00, 1, 4'h2, 32'h0, 32'h0000007F};
    #2;
    check("rst_req", 32'(bus.dbus_req), 32'd0);
    check("rst_we", 32'(bus.dbus_we), 32'd0);
    check("rst_addr", bus.dbus_addr, 32'd0);
    check("rst_be", 32'(bus.dbus_be), 32'd0);
    check("rst_wdata", bus.dbus_wdata, 32'd0);
    check("rst_load", load_data_m, 32'd0);
    check("rst_bus_err", 32'(bus_err), 32'd0);
    check("rst_align_err", 32'(align_err), 32'd0);
    check("rst_stall_idle", 32'(stall_m), 32'd0);
    mem_valid_m = 1'b1; mem_read_m = 1'b1;
    #1 check("rst_stall_comb", 32'(stall_m), 32'd1);
    mem_valid_m = 1'b0; mem_read_m = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    foreach (tbl[i])
      access(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sx, tbl[i].a, tbl[i].wd, tbl[i].rdat,
             tbl[i].wc, tbl[i].e_be, tbl[i].e_wd, tbl[i].e_ld);
    // timeout: no ack ever
    @(negedge clk);
    mem_valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; mem_size_m = 2'b00; addr_m = 32'h40;
    n = 0;
    @(negedge clk);
    for (int i = 0; i < 10 && bus.dbus_req; i++) begin
      n++;
      @(negedge clk);
    end
    check("to_wait_cycles", 32'(n), 32'(TO));
    check("to_bus_err", 32'(bus_err), 32'd1);
    check("to_load_zero", load_data_m, 32'd0);
    check("to_stall_done", 32'(stall_m), 32'd0);
    mem_valid_m = 1'b0;
    @(negedge clk);
    check("to_err_pulse", 32'(bus_err), 32'd0);
    check("to_idle_req", 32'(bus.dbus_req), 32'd0);
    last_ld = '0;
    // valid without read/write, and read without valid, are not accesses
    mem_valid_m = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b0;
    #1 check("noacc_stall", 32'(stall_m), 32'd0);
    mem_valid_m = 1'b0; mem_read_m = 1'b1;
    #1 check("bubble_stall", 32'(stall_m), 32'd0);
    @(negedge clk);
    check("bubble_req", 32'(bus.dbus_req), 32'd0);
    // reset mid-WAIT
    mem_valid_m = 1'b1; mem_read_m = 1'b0; mem_write_m = 1'b1; mem_size_m = 2'b10; addr_m = 32'h50; wdata_m = 32'hA5;
    @(negedge clk);
    check("rstw_pre_req", 32'(bus.dbus_req), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_req", 32'(bus.dbus_req), 32'd0);
    check("rstw_we", 32'(bus.dbus_we), 32'd0);
    check("rstw_be", 32'(bus.dbus_be), 32'd0);
    mem_valid_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.dbus_req || stall_m) n++;
    end
    check("rstw_quiet_after", 32'(n), 32'd0);
    last_ld = '0;
`ifdef LSU_ALIGN_CHECK_EN
    @(negedge clk);
    mem_valid_m = 1'b1; mem_read_m = 1'b1; mem_write_m = 1'b0; mem_size_m = 2'b00; addr_m = 32'h3002;
    #1 check("al_stall_idle", 32'(stall_m), 32'd1);
    @(negedge clk);
    check("al_no_req", 32'(bus.dbus_req), 32'd0);
    check("al_err", 32'(align_err), 32'd1);
    check("al_stall_done", 32'(stall_m), 32'd0);
    check("al_load_kept", load_data_m, last_ld);
    mem_valid_m = 1'b0;
    @(negedge clk);
    check("al_err_pulse", 32'(align_err), 32'd0);
    check("al_idle_req", 32'(bus.dbus_req), 32'd0);
`else
    access(1'b1, 1'b0, 2'b00, 1'b0, 32'h3002, 32'h0, 32'h0BADF00D, 1, 4'hF, 32'h0, 32'h0BADF00D);
    model(2'b01, 1'b1, 32'h2003, 32'h0, 32'h9ABC1234, be, ewd, eld);
    access(1'b1, 1'b0, 2'b01, 1'b1, 32'h2003, 32'h0, 32'h9ABC1234, 2, be, ewd, eld);
`endif
    for (int i = 0; i < 200; i++) begin
      op = int'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 3));
      a = $urandom(); wd = $urandom(); rdat = $urandom();
`ifdef LSU_ALIGN_CHECK_EN
      if (sz == 2'b01) a[0] = 1'b0;
      else if (sz != 2'b10) a[1:0] = 2'b00;
`endif
      model(sz, 1'($urandom_range(0, 1)), a, wd, rdat, be, ewd, eld);
      n = int'($urandom_range(0, 1));
      model(sz, n[0], a, wd, rdat, be, ewd, eld);
      access(op != 1, op != 0, sz, n[0], a, wd, rdat, int'($urandom_range(1, TO - 1)),
             be, ewd, op == 0 ? eld : last_ld);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, nerr);
    $finish;
  end
endmodule
